timestamp_word_decoder: RTL and testbench
=========================================

# timestamp_word_decoder

Downstream consumer of the timestamp core's 32-bit output FIFO. Pops words over the FIFO_READ/FIFO_EMPTY/FIFO_DATA interface and checks the identifier and word-type sequence. Reassembles each low/high word pair into one 48-bit timestamp, presented on a registered valid/ready port to on-chip logic such as a trigger-distance monitor or event builder. Protocol violations are counted, not propagated.

## Interface
- IDENTIFIER, 4'b0001: identifier expected in bits 31:28; must match the upstream core.
- BUS_CLK  in  1  single clock for all logic.
- BUS_RST  in  1  synchronous, active-high reset.
- FIFO_EMPTY  in  1  upstream FIFO empty; FIFO_DATA valid whenever low (first-word fall-through).
- FIFO_READ  out  1  pop strobe; combinational, never asserted while FIFO_EMPTY=1.
- FIFO_DATA  in  32  word: [31:28] ID, [27:24] type (0x1 = ts[23:0], 0x2 = ts[47:24]), [23:0] payload.
- TS_VALID  out  1  registered; timestamp available.
- TS_READY  in  1  consumer accepts; transfer when TS_VALID & TS_READY.
- TS_DATA  out  48  reassembled timestamp.
- TS_DELTA  out  48  TS_DATA minus previous accepted timestamp (TS_DELTA_EN only).
- ERR_CNT  out  8  saturating count of sequence errors.
- DROP_CNT  out  8  saturating count of foreign-ID words discarded.

## Operation
- Reset: state S_LOW, TS_VALID=0, TS_DATA=0, TS_DELTA=0, ERR_CNT=0, DROP_CNT=0, low latch=0, previous-timestamp register=0, first flag=1.
- FIFO_READ = !FIFO_EMPTY & (state==S_LOW | state==S_HIGH). Every word presented in these states is consumed in that cycle.
- Foreign ID (bits 31:28 != IDENTIFIER): drop the word, DROP_CNT+1, state unchanged. This check takes precedence over the type checks below.
- S_LOW:
  - Type 0x1: latch payload as low24, go to S_HIGH.
  - Any other type: ERR_CNT+1, stay in S_LOW.
- S_HIGH:
  - Type 0x2: TS_DATA <= {payload, low24}, TS_VALID <= 1, go to S_OUT.
  - Type 0x1 (high word missing): ERR_CNT+1, re-latch low24, stay in S_HIGH.
  - Any other type: ERR_CNT+1, go to S_LOW.
- S_OUT:
  - FIFO_READ=0.
  - Hold TS_VALID and TS_DATA stable until TS_READY.
  - On handshake: TS_VALID <= 0, previous <= TS_DATA, first <= 0, go to S_LOW.
- Counters saturate at 255 and clear only on BUS_RST.
- No TS_READY dependency outside S_OUT; back-pressure only stalls FIFO popping.

## Timing
- High word popped in cycle N → TS_VALID=1 in cycle N+1.
- Minimum 3 cycles per timestamp (low pop, high pop, output handshake) with TS_READY held high and the FIFO never empty.
- Gaps (FIFO_EMPTY=1) between the low and high words are allowed; S_HIGH waits indefinitely.
- BUS_RST mid-pair or mid-output: partial data discarded, TS_VALID drops in the cycle after reset is sampled, and no word is popped while reset is asserted.
- Simultaneous foreign-ID drop and counter saturation: the counter stays at 255 and the word is still popped.

## Configuration
- TIMESTAMP_DELTA_EN defined:
  - TS_DELTA is loaded together with TS_DATA as (new − previous) mod 2^48.
  - On the first timestamp after reset, TS_DELTA=0.
  - Wrap-around of the 48-bit counter yields the correct modular difference.
- Not defined:
  - TS_DELTA is tied to 0.
  - The previous-timestamp register and first flag are not instantiated.

## Test plan
- Pair 0x11ABCDEF, 0x12000123 with TS_READY=1 → TS_DATA=0x000123ABCDEF one cycle after the second pop; ERR_CNT=0.
- Pair presented, TS_READY held 0 for 10 cycles → TS_VALID and TS_DATA stable, FIFO_READ=0 throughout, and the next pair is not popped until the handshake.
- Words 0x12000005, 0x11000001, 0x11000002, 0x12000003 → one timestamp, 0x000003000002; ERR_CNT=2.
- Foreign word 0x21FFFFFF between the low and high words of a valid pair → timestamp intact; DROP_CNT=1, ERR_CNT=0.
- TIMESTAMP_DELTA_EN: timestamps 0xFFFFFFFFFFF0 then 0x000000000010 → deltas 0, then 0x20.
- BUS_RST asserted in S_HIGH, then a fresh pair → all outputs 0 after reset, and the new pair decodes correctly with no stale low half; 300 errors → ERR_CNT=255.

Source files
------------

// File: rtl/timestamp_word_decoder_if.sv
// Bundles the FIFO pop side and the timestamp output side of the word decoder.
// master: the decoder; slave: the FIFO/consumer environment.
interface timestamp_word_decoder_if;
  logic        FIFO_EMPTY;
  logic        FIFO_READ;
  logic [31:0] FIFO_DATA;
  logic        TS_VALID;
  logic        TS_READY;
  logic [47:0] TS_DATA;
  logic [47:0] TS_DELTA;
  logic [7:0]  ERR_CNT;
  logic [7:0]  DROP_CNT;

  modport master (
    input  FIFO_EMPTY, FIFO_DATA, TS_READY,
    output FIFO_READ, TS_VALID, TS_DATA, TS_DELTA, ERR_CNT, DROP_CNT
  );

  modport slave (
    output FIFO_EMPTY, FIFO_DATA, TS_READY,
    input  FIFO_READ, TS_VALID, TS_DATA, TS_DELTA, ERR_CNT, DROP_CNT
  );
endinterface

// File: rtl/timestamp_word_decoder.sv
// Pops low/high timestamp words from a fall-through FIFO and reassembles 48-bit timestamps.
// Define TIMESTAMP_DELTA_EN to also produce the difference to the previous accepted timestamp.
module timestamp_word_decoder #(
  parameter logic [3:0] IDENTIFIER = 4'b0001
) (
  input logic                       BUS_CLK,
  input logic                       BUS_RST,
  timestamp_word_decoder_if.master  bus
);

  typedef enum logic [1:0] {S_LOW, S_HIGH, S_OUT} state_t;

  state_t      state;
  logic [23:0] low24;
  logic        ts_valid;
  logic [47:0] ts_data;
  logic [7:0]  err_cnt;
  logic [7:0]  drop_cnt;

  logic [3:0]  word_id;
  logic [3:0]  word_type;
  logic [23:0] payload;
  logic [47:0] new_ts;
  logic        pop;

  assign word_id   = bus.FIFO_DATA[31:28];
  assign word_type = bus.FIFO_DATA[27:24];
  assign payload   = bus.FIFO_DATA[23:0];
  assign new_ts    = {payload, low24};

  // Reset gates the pop so nothing is lost while the decoder is being cleared.
  assign pop = !BUS_RST && !bus.FIFO_EMPTY && (state == S_LOW || state == S_HIGH);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef TIMESTAMP_DELTA_EN
  logic [47:0] prev_ts;
  logic        first;
  logic [47:0] ts_delta;
`endif

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state    <= S_LOW;
      low24    <= '0;
      ts_valid <= 1'b0;
      ts_data  <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
`ifdef TIMESTAMP_DELTA_EN
      prev_ts  <= '0;
      first    <= 1'b1;
      ts_delta <= '0;
`endif
    end else begin
      case (state)
        S_LOW, S_HIGH: begin
          if (pop) begin
            if (word_id != IDENTIFIER) begin
              drop_cnt <= sat_inc(drop_cnt);
            end else if (state == S_LOW) begin
              if (word_type == 4'h1) begin
                low24 <= payload;
                state <= S_HIGH;
              end else begin
                err_cnt <= sat_inc(err_cnt);
              end
            end else begin
              if (word_type == 4'h2) begin
                ts_data  <= new_ts;
                ts_valid <= 1'b1;
                state    <= S_OUT;
`ifdef TIMESTAMP_DELTA_EN
                ts_delta <= first ? 48'd0 : new_ts - prev_ts;
`endif
              end else if (word_type == 4'h1) begin
                // A second low word supersedes the orphaned one.
                err_cnt <= sat_inc(err_cnt);
                low24   <= payload;
              end else begin
                err_cnt <= sat_inc(err_cnt);
                state   <= S_LOW;
              end
            end
          end
        end
        S_OUT: begin
          if (bus.TS_READY) begin
            ts_valid <= 1'b0;
            state    <= S_LOW;
`ifdef TIMESTAMP_DELTA_EN
            prev_ts  <= ts_data;
            first    <= 1'b0;
`endif
          end
        end
        default: state <= S_LOW;
      endcase
    end
  end

  assign bus.FIFO_READ = pop;
  assign bus.TS_VALID  = ts_valid;
  assign bus.TS_DATA   = ts_data;
  assign bus.ERR_CNT   = err_cnt;
  assign bus.DROP_CNT  = drop_cnt;
`ifdef TIMESTAMP_DELTA_EN
  assign bus.TS_DELTA  = ts_delta;
`else
  assign bus.TS_DELTA  = '0;
`endif

endmodule

// File: tb/tb_timestamp_word_decoder.sv
// Directed bench for timestamp_word_decoder: vector table of word sequences plus
// hand-written back-pressure, reset, saturation and delta sequences.
module tb_timestamp_word_decoder;

  logic BUS_CLK = 1'b0;
  logic BUS_RST = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  timestamp_word_decoder_if bus ();

  timestamp_word_decoder dut (
    .BUS_CLK (BUS_CLK),
    .BUS_RST (BUS_RST),
    .bus     (bus.master)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  typedef struct packed {
    logic [3:0][31:0] words;
    logic [2:0]       n_words;
    logic             exp_valid;
    logic [47:0]      exp_ts;
    logic [7:0]       exp_err;
    logic [7:0]       exp_drop;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3, input logic [2:0] n,
                              input logic v, input logic [47:0] ts,
                              input logic [7:0] err, drop);
    vec_t r;
    r.words     = {w3, w2, w1, w0};
    r.n_words   = n;
    r.exp_valid = v;
    r.exp_ts    = ts;
    r.exp_err   = err;
    r.exp_drop  = drop;
    return r;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic v, input logic [47:0] ts,
                              input logic [47:0] delta, input logic [7:0] err, drop);
    check({name, ".valid"}, {47'd0, bus.TS_VALID}, {47'd0, v});
    check({name, ".data"},  bus.TS_DATA, ts);
    check({name, ".delta"}, bus.TS_DELTA, delta);
    check({name, ".err"},   {40'd0, bus.ERR_CNT}, {40'd0, err});
    check({name, ".drop"},  {40'd0, bus.DROP_CNT}, {40'd0, drop});
  endtask

  task automatic do_reset();
    BUS_RST = 1'b1;
    bus.FIFO_EMPTY = 1'b1;
    bus.TS_READY = 1'b0;
    @(posedge BUS_CLK);
    #1;
    BUS_RST = 1'b0;
  endtask

  // Present one word and wait (bounded) until the decoder pops it.
  task automatic apply_stimulus(input logic [31:0] w);
    bit popped = 0;
    bus.FIFO_DATA  = w;
    bus.FIFO_EMPTY = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge BUS_CLK);
      if (bus.FIFO_READ) begin
        popped = 1;
        break;
      end
    end
    if (popped) begin
      @(posedge BUS_CLK);
      #1;
    end else begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL pop_timeout: word 0x%08h never popped, required pop", w);
    end
    bus.FIFO_EMPTY = 1'b1;
  endtask

  task automatic handshake(input string name);
    bus.TS_READY = 1'b1;
    @(posedge BUS_CLK);
    #1;
    bus.TS_READY = 1'b0;
    check({name, ".valid_drop"}, {47'd0, bus.TS_VALID}, 48'd0);
  endtask

  vec_t        vecs [6];
  logic [47:0] exp_delta;

  initial begin
    bus.FIFO_EMPTY = 1'b1;
    bus.FIFO_DATA  = '0;
    bus.TS_READY   = 1'b0;

    vecs[0] = mk(32'h11ABCDEF, 32'h12000123, 32'h0, 32'h0, 3'd2, 1'b1, 48'h000123ABCDEF, 8'd0, 8'd0);
    vecs[1] = mk(32'h12000005, 32'h11000001, 32'h11000002, 32'h12000003, 3'd4, 1'b1, 48'h000003000002, 8'd2, 8'd0);
    vecs[2] = mk(32'h11000010, 32'h21FFFFFF, 32'h12000020, 32'h0, 3'd3, 1'b1, 48'h000020000010, 8'd0, 8'd1);
    vecs[3] = mk(32'h11000001, 32'h13000000, 32'h11000007, 32'h12000008, 3'd4, 1'b1, 48'h000008000007, 8'd1, 8'd0);
    vecs[4] = mk(32'h11FFFFFF, 32'h12FFFFFF, 32'h0, 32'h0, 3'd2, 1'b1, 48'hFFFFFFFFFFFF, 8'd0, 8'd0);
    vecs[5] = mk(32'h31000000, 32'h0, 32'h0, 32'h0, 3'd1, 1'b0, 48'h0, 8'd0, 8'd1);

    // Reset state, and no pop while reset is held with data available.
    BUS_RST = 1'b1;
    bus.FIFO_DATA  = 32'h11000001;
    bus.FIFO_EMPTY = 1'b0;
    @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    check("reset.fifo_read", {47'd0, bus.FIFO_READ}, 48'd0);
    check_output("reset", 1'b0, 48'd0, 48'd0, 8'd0, 8'd0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int j = 0; j < int'(vecs[i].n_words); j++) apply_stimulus(vecs[i].words[j]);
      check_output($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ts, 48'd0,
                   vecs[i].exp_err, vecs[i].exp_drop);
      if (vecs[i].exp_valid) handshake($sformatf("vec%0d", i));
    end

    // Back-pressure: output held, next word not popped until handshake.
    do_reset();
    apply_stimulus(32'h11000011);
    apply_stimulus(32'h12000022);
    bus.FIFO_DATA  = 32'h11000055;
    bus.FIFO_EMPTY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge BUS_CLK);
      check("bp.fifo_read", {47'd0, bus.FIFO_READ}, 48'd0);
      check("bp.valid", {47'd0, bus.TS_VALID}, 48'd1);
      check("bp.data", bus.TS_DATA, 48'h000022000011);
    end
    handshake("bp");
    apply_stimulus(32'h11000055);
    apply_stimulus(32'h12000066);
`ifdef TIMESTAMP_DELTA_EN
    exp_delta = 48'h000044000044;
`else
    exp_delta = 48'd0;
`endif
    check_output("bp.next", 1'b1, 48'h000066000055, exp_delta, 8'd0, 8'd0);
    handshake("bp.next");

    // Reset in S_HIGH discards the latched low half.
    do_reset();
    apply_stimulus(32'h110000AA);
    do_reset();
    check_output("rst_high", 1'b0, 48'd0, 48'd0, 8'd0, 8'd0);
    apply_stimulus(32'h12000001);
    check_output("rst_high.orphan", 1'b0, 48'd0, 48'd0, 8'd1, 8'd0);
    apply_stimulus(32'h11000002);
    apply_stimulus(32'h12000003);
    check_output("rst_high.pair", 1'b1, 48'h000003000002, 48'd0, 8'd1, 8'd0);

    // Reset while presenting a timestamp drops TS_VALID on the next cycle.
    do_reset();
    check_output("rst_out", 1'b0, 48'd0, 48'd0, 8'd0, 8'd0);

    // Error and drop counters saturate; dropped words are still popped.
    do_reset();
    for (int i = 0; i < 300; i++) apply_stimulus(32'h13000000);
    for (int i = 0; i < 260; i++) apply_stimulus(32'h21000000);
    check_output("sat", 1'b0, 48'd0, 48'd0, 8'd255, 8'd255);
    apply_stimulus(32'h11000004);
    apply_stimulus(32'h12000005);
    check_output("sat.pair", 1'b1, 48'h000005000004, 48'd0, 8'd255, 8'd255);

    // Delta across 48-bit wrap-around.
    do_reset();
    apply_stimulus(32'h11FFFFF0);
    apply_stimulus(32'h12FFFFFF);
    check_output("wrap.first", 1'b1, 48'hFFFFFFFFFFF0, 48'd0, 8'd0, 8'd0);
    handshake("wrap.first");
    apply_stimulus(32'h11000010);
    apply_stimulus(32'h12000000);
`ifdef TIMESTAMP_DELTA_EN
    exp_delta = 48'h20;
`else
    exp_delta = 48'd0;
`endif
    check_output("wrap.second", 1'b1, 48'h000000000010, exp_delta, 8'd0, 8'd0);
    handshake("wrap.second");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
